ssdt_rr_buf: RTL and testbench

- Parametrised successor to the single-channel SSDT back-to-back stage.
- Accepts N_CH independent valid-qualified SSDT data streams, each into its own FIFO of DEPTH entries.
- Drains the FIFOs round-robin onto one registered output with ready/valid backpressure; every output word is tagged with its source channel.
- Sits between the SSDT stimulus drivers and the single-channel consumer; per-channel sticky overflow flags.

---
 rtl/ssdt_rr_buf_if.sv | 37 +++
 rtl/ssdt_rr_buf.sv | 91 +++++++++
 tb/tb_ssdt_rr_buf.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ssdt_rr_buf_if.sv
// ssdt_rr_buf_if: bundle of per-channel inputs, tagged ready/valid output, ch_full/ovf status and ovf_clr; in_par/out_perr exist only with SSDT_RR_BUF_PARITY_EN
interface ssdt_rr_buf_if #(
  parameter int DATA_W = 4,
  parameter int N_CH = 4
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic [N_CH-1:0] in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic out_ready;
  logic [N_CH-1:0] ch_full;
  logic [N_CH-1:0] ovf;
  logic ovf_clr;
`ifdef SSDT_RR_BUF_PARITY_EN
  logic [N_CH-1:0] in_par;
  logic out_perr;
  modport master (
    output in_valid, in_data, in_par, out_ready, ovf_clr,
    input out_valid, out_data, out_ch, out_perr, ch_full, ovf
  );
  modport slave (
    input in_valid, in_data, in_par, out_ready, ovf_clr,
    output out_valid, out_data, out_ch, out_perr, ch_full, ovf
  );
`else
  modport master (
    output in_valid, in_data, out_ready, ovf_clr,
    input out_valid, out_data, out_ch, ch_full, ovf
  );
  modport slave (
    input in_valid, in_data, out_ready, ovf_clr,
    output out_valid, out_data, out_ch, ch_full, ovf
  );
`endif
endinterface

// File: rtl/ssdt_rr_buf.sv
// ssdt_rr_buf: N_CH per-channel FIFOs drained round-robin onto one registered channel-tagged ready/valid output; ports clk, rst (async, active-high), bus (ssdt_rr_buf_if.slave); optional parity via SSDT_RR_BUF_PARITY_EN
module ssdt_rr_buf #(
  parameter int DATA_W = 4,
  parameter int N_CH = 4,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ssdt_rr_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
`ifdef SSDT_RR_BUF_PARITY_EN
  localparam int EW = DATA_W + 1;
`else
  localparam int EW = DATA_W;
`endif
  logic [N_CH-1:0][DEPTH-1:0][EW-1:0] mem;
  logic [N_CH-1:0][AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
  logic [N_CH-1:0][EW-1:0] entry;
  logic [N_CH-1:0] empty, full, full_n, push, pop, ovf_set;
  logic [CW-1:0] rr, grant, k;
  logic [EW-1:0] head;
  logic any, load;
  always_comb begin
    load = !bus.out_valid || bus.out_ready;
    grant = '0;
    any = 1'b0;
    k = '0;
    for (int c = 0; c < N_CH; c++) begin
      empty[c] = wr_ptr[c] == rd_ptr[c];
      full[c] = wr_ptr[c] == {~rd_ptr[c][AW], rd_ptr[c][AW-1:0]};
    end
    for (int i = N_CH; i >= 1; i--) begin
      k = CW'((int'(rr) + i) % N_CH);
      if (!empty[k]) begin
        grant = k;
        any = 1'b1;
      end
    end
    head = mem[grant][rd_ptr[grant][AW-1:0]];
    for (int c = 0; c < N_CH; c++) begin
      pop[c] = load && any && grant == CW'(c);
      push[c] = bus.in_valid[c] && (!full[c] || pop[c]);
      ovf_set[c] = bus.in_valid[c] && full[c] && !pop[c];
      wr_n[c] = wr_ptr[c] + (AW+1)'(push[c]);
      rd_n[c] = rd_ptr[c] + (AW+1)'(pop[c]);
      full_n[c] = wr_n[c] == {~rd_n[c][AW], rd_n[c][AW-1:0]};
`ifdef SSDT_RR_BUF_PARITY_EN
      entry[c] = {bus.in_par[c], bus.in_data[c*DATA_W +: DATA_W]};
`else
      entry[c] = bus.in_data[c*DATA_W +: DATA_W];
`endif
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++)
      if (push[c]) mem[c][wr_ptr[c][AW-1:0]] <= entry[c];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr <= CW'(N_CH - 1);
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch <= '0;
      bus.ch_full <= '0;
      bus.ovf <= '0;
`ifdef SSDT_RR_BUF_PARITY_EN
      bus.out_perr <= 1'b0;
`endif
    end else begin
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      bus.ch_full <= full_n;
      bus.ovf <= ovf_set | (bus.ovf_clr ? '0 : bus.ovf);
      if (load) begin
        bus.out_valid <= any;
        if (any) begin
          bus.out_data <= head[DATA_W-1:0];
          bus.out_ch <= grant;
          rr <= grant;
`ifdef SSDT_RR_BUF_PARITY_EN
          bus.out_perr <= ^head;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_ssdt_rr_buf.sv
// tb_ssdt_rr_buf: directed stimulus with a scoreboard queue checked by a negedge output monitor
module tb_ssdt_rr_buf;
  logic clk, rst;
  int tests = 0;
  int fails = 0;
  logic [5:0] q[$];
  logic [5:0] e;
  ssdt_rr_buf_if #(.DATA_W(4), .N_CH(4)) bus ();
  ssdt_rr_buf #(.DATA_W(4), .N_CH(4), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", n, a, x);
    end
  endtask
  task automatic sb_push(input int ch, input int d);
    q.push_back({2'(ch), 4'(d)});
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got ch %0d data %0h, required none", bus.out_ch, bus.out_data);
      end else begin
        e = q.pop_front();
        if ({bus.out_ch, bus.out_data} !== e) begin
          fails++;
          $display("FAIL word: got ch %0d data %0h, required ch %0d data %0h", bus.out_ch, bus.out_data, e[5:4], e[3:0]);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr = 1'b0;
`ifdef SSDT_RR_BUF_PARITY_EN
    bus.in_par = '0;
`endif
    tick;
    tick;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_ch", 32'(bus.out_ch), 0);
    chk("rst_ch_full", 32'(bus.ch_full), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0001;
    bus.in_data = 16'h000A;
    sb_push(0, 4'hA);
    tick;
    bus.in_valid = '0;
    tick;
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_data", 32'(bus.out_data), 32'hA);
    chk("single_ch", 32'(bus.out_ch), 0);
    tick;
    chk("single_idle", 32'(bus.out_valid), 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.in_valid = 4'hF;
    bus.in_data = 16'h4321;
    for (int c = 0; c < 4; c++) sb_push(c, c + 1);
    tick;
    bus.in_valid = '0;
    repeat (5) tick;
    chk("rr_idle", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0100;
    bus.in_data = 16'h0300;
    tick;
    bus.in_data = 16'h0500;
    tick;
    bus.in_data = 16'h0700;
    tick;
    bus.in_valid = '0;
    sb_push(2, 3);
    sb_push(2, 5);
    sb_push(2, 7);
    tick;
    chk("bp_valid", 32'(bus.out_valid), 1);
    chk("bp_data", 32'(bus.out_data), 3);
    chk("bp_ch", 32'(bus.out_ch), 2);
    chk("bp_ch_full", 32'(bus.ch_full), 0);
    bus.out_ready = 1'b1;
    repeat (4) tick;
    chk("bp_idle", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0010;
    for (int i = 1; i <= 6; i++) begin
      bus.in_data = 16'(i << 4);
      tick;
    end
    bus.in_valid = '0;
    for (int i = 1; i <= 5; i++) sb_push(1, i);
    tick;
    chk("ovf_ch_full", 32'(bus.ch_full), 32'b0010);
    chk("ovf_set", 32'(bus.ovf), 32'b0010);
    chk("ovf_head", 32'(bus.out_data), 1);
    repeat (2) tick;
    chk("ovf_sticky", 32'(bus.ovf), 32'b0010);
    bus.out_ready = 1'b1;
    repeat (6) tick;
    chk("ovf_drained", 32'(bus.out_valid), 0);
    chk("ovf_drained_full", 32'(bus.ch_full), 0);
    chk("ovf_after_drain", 32'(bus.ovf), 32'b0010);
    bus.ovf_clr = 1'b1;
    tick;
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.ovf), 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0001;
    for (int i = 9; i <= 13; i++) begin
      bus.in_data = 16'(i);
      sb_push(0, i);
      tick;
    end
    bus.in_valid = '0;
    tick;
    chk("fp_full", 32'(bus.ch_full), 32'b0001);
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0001;
    bus.in_data = 16'h000E;
    sb_push(0, 4'hE);
    tick;
    bus.in_valid = '0;
    chk("fp_still_full", 32'(bus.ch_full), 32'b0001);
    chk("fp_no_ovf", 32'(bus.ovf), 0);
    repeat (7) tick;
    chk("fp_idle", 32'(bus.out_valid), 0);
    chk("fp_empty", 32'(bus.ch_full), 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b1000;
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 16'(i << 12);
      tick;
    end
    bus.in_valid = '0;
    tick;
    chk("mr_pre_valid", 32'(bus.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_async_valid", 32'(bus.out_valid), 0);
    chk("mr_async_data", 32'(bus.out_data), 0);
    tick;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick;
    chk("mr_no_stale", 32'(bus.out_valid), 0);
    chk("mr_ch_full", 32'(bus.ch_full), 0);
    chk("mr_ovf", 32'(bus.ovf), 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d words outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
